// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared constants and helpers for the two-port memory arbiter.
//   ARB_IDLE/ARB_OWN0/ARB_OWN1 : FSM state encodings (which port owns the memory)
//   port_onehot()              : converts a port index into a one-hot grant vector
package mem_arbiter_pkg;

  typedef logic [1:0] arb_state_t;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_OWN0 = 2'd1;
  localparam logic [1:0] ARB_OWN1 = 2'd2;

  // One-hot grant vector for a port index (0 = cpu, 1 = loader/DMA).
  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side bus of the memory arbiter.
//   req_i/we_i         per-port request and write enable (bit 0 = cpu, bit 1 = loader)
//   addr0_i/addr1_i    per-port address
//   wdata0_i/wdata1_i  per-port write data
//   gnt_o              one-hot grant (combinational, same cycle as the access)
//   rvalid_o           per-port read-data strobe, one cycle after a read grant
//   rdata_o            shared read data
// modport master: the requesters; modport slave: the arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8
);
  logic [1:0]            req_i;
  logic [1:0]            we_i;
  logic [ADDR_WIDTH-1:0] addr0_i;
  logic [ADDR_WIDTH-1:0] addr1_i;
  logic [DATA_WIDTH-1:0] wdata0_i;
  logic [DATA_WIDTH-1:0] wdata1_i;
  logic [1:0]            gnt_o;
  logic [1:0]            rvalid_o;
  logic [DATA_WIDTH-1:0] rdata_o;

  modport master (
    output req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i,
    output gnt_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/mem_arbiter_burst_counter.sv
// mem_arbiter_burst_counter: saturating count of consecutive grants to the current owner.
//   clk, rst   clock and asynchronous active-high reset
//   load_one   start a new burst (count becomes 1)
//   inc        another grant to the same owner (count +1, saturating at MAX_BURST)
//   at_max     count has reached MAX_BURST
module mem_arbiter_burst_counter #(
  parameter int MAX_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load_one,
  input  logic inc,
  output logic at_max
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign at_max = (cnt_q == CNT_W'(MAX_BURST));

  // Next count: load 1, increment until saturation, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load_one) begin
      cnt_d = CNT_W'(1);
    end else if (inc && !at_max) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port byte memory between the cpu (port 0) and the
// loader/DMA (port 1) with round-robin arbitration and bounded bursts.
//   clk, rst        clock and asynchronous active-high reset
//   bus             requester bus (mem_arbiter_if.slave)
//   mem_address     address to memory, from the granted port (port 0 when idle)
//   mem_write_data  write data to memory, from the granted port (port 0 when idle)
//   mem_write_en    write strobe to memory (granted port is writing)
//   mem_read_data   synchronous read data from memory, passed straight to rdata_o
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_arbiter_if.slave          bus,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write_en,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  arb_state_t state_q, state_d;
  logic       last_q, last_d;
  logic [1:0] rvalid_q, rvalid_d;
  logic [1:0] gnt_raw_s;
  logic [1:0] gnt_s;
  logic       at_max_s;
  logic       cnt_load_s;
  logic       cnt_inc_s;

  // Grant decision from the current owner and the live requests.
  always_comb begin
    gnt_raw_s = 2'b00;
    case (state_q)
      ARB_IDLE: begin
        if (bus.req_i[0] && bus.req_i[1]) begin
          gnt_raw_s = port_onehot(~last_q);
        end else if (bus.req_i[0]) begin
          gnt_raw_s = 2'b01;
        end else if (bus.req_i[1]) begin
          gnt_raw_s = 2'b10;
        end else begin
          gnt_raw_s = 2'b00;
        end
      end
      ARB_OWN0: begin
        // Owner keeps the memory unless the other port waits and the burst is used up.
        if (bus.req_i[0] && !(bus.req_i[1] && at_max_s)) begin
          gnt_raw_s = 2'b01;
        end else if (bus.req_i[1]) begin
          gnt_raw_s = 2'b10;
        end else begin
          gnt_raw_s = 2'b00;
        end
      end
      ARB_OWN1: begin
        if (bus.req_i[1] && !(bus.req_i[0] && at_max_s)) begin
          gnt_raw_s = 2'b10;
        end else if (bus.req_i[0]) begin
          gnt_raw_s = 2'b01;
        end else begin
          gnt_raw_s = 2'b00;
        end
      end
      default: begin
        gnt_raw_s = 2'b00;
      end
    endcase
  end

  // No grant may reach memory while reset is held.
  assign gnt_s     = gnt_raw_s & {2{~rst}};
  assign bus.gnt_o = gnt_s;

  // Next owner, round-robin pointer, burst control and read-return strobes.
  always_comb begin
    state_d    = ARB_IDLE;
    last_d     = last_q;
    cnt_load_s = 1'b0;
    cnt_inc_s  = 1'b0;
    rvalid_d   = gnt_s & ~bus.we_i;
    if (gnt_s[0]) begin
      state_d    = ARB_OWN0;
      last_d     = 1'b0;
      cnt_load_s = (state_q != ARB_OWN0);
      cnt_inc_s  = (state_q == ARB_OWN0);
    end else if (gnt_s[1]) begin
      state_d    = ARB_OWN1;
      last_d     = 1'b1;
      cnt_load_s = (state_q != ARB_OWN1);
      cnt_inc_s  = (state_q == ARB_OWN1);
    end else begin
      state_d    = ARB_IDLE;
      last_d     = last_q;
    end
  end

  // Memory mux: follows the granted port; port 0 drives the bus when nobody is granted.
  always_comb begin
    if (gnt_s[1]) begin
      mem_address    = bus.addr1_i;
      mem_write_data = bus.wdata1_i;
    end else begin
      mem_address    = bus.addr0_i;
      mem_write_data = bus.wdata0_i;
    end
  end

  assign mem_write_en = |(gnt_s & bus.we_i);
  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = mem_read_data;

  mem_arbiter_burst_counter #(
    .MAX_BURST (MAX_BURST)
  ) u_burst_counter (
    .clk      (clk),
    .rst      (rst),
    .load_one (cnt_load_s),
    .inc      (cnt_inc_s),
    .at_max   (at_max_s)
  );

  // Owner, round-robin pointer and read-valid registers; last=1 lets port 0 win first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      last_q   <= 1'b1;
      rvalid_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      rvalid_q <= rvalid_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data;
  logic          mem_write_en;
  logic [DW-1:0] mem_read_data;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write_en   (mem_write_en),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  // Environment memory: 256 bytes, synchronous read.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_address[7:0]] <= mem_write_data;
    mem_read_data <= mem[mem_address[7:0]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: who owns the memory, how long its run is, who was served last,
  // and a shadow copy of memory contents.
  int         own_m  = -1;
  int         run_m  = 0;
  int         last_m = 1;
  logic [7:0] ref_mem [256];

  typedef struct {
    int         port;
    logic [7:0] data;
    int         due;
  } exp_t;
  exp_t sb[$];

  function automatic int pick(input logic [1:0] req);
    int o;
    if (own_m < 0) begin
      if (req == 2'b11) return 1 - last_m;
      if (req[0]) return 0;
      if (req[1]) return 1;
      return -1;
    end
    o = own_m;
    if (req[o] && !(req[1-o] && run_m >= MB)) return o;
    if (req[1-o]) return 1 - o;
    return -1;
  endfunction

  task automatic model_reset();
    own_m  = -1;
    run_m  = 0;
    last_m = 1;
    sb.delete();
  endtask

  // One bus cycle: drive at the falling edge, check combinational outputs, advance the model.
  task automatic do_cycle(input logic rst_v, input logic [1:0] req, input logic [1:0] we,
                          input logic [31:0] a0, input logic [31:0] a1,
                          input logic [7:0] d0, input logic [7:0] d1);
    int          g;
    logic [1:0]  exp_gnt;
    logic [31:0] exp_addr;
    logic [7:0]  exp_wd;
    logic        exp_we;
    @(negedge clk);
    rst          = rst_v;
    bus.req_i    = req;
    bus.we_i     = we;
    bus.addr0_i  = a0;
    bus.addr1_i  = a1;
    bus.wdata0_i = d0;
    bus.wdata1_i = d1;
    #1;
    if (rst_v) begin
      model_reset();
      g = -1;
      chk("rvalid_in_reset", {30'd0, bus.rvalid_o}, 32'd0);
    end else begin
      g = pick(req);
    end
    exp_gnt  = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
    exp_addr = (g == 1) ? a1 : a0;
    exp_wd   = (g == 1) ? d1 : d0;
    exp_we   = (g >= 0) ? we[g] : 1'b0;
    chk("gnt", {30'd0, bus.gnt_o}, {30'd0, exp_gnt});
    chk("mem_address", mem_address, exp_addr);
    chk("mem_write_data", {24'd0, mem_write_data}, {24'd0, exp_wd});
    chk("mem_write_en", {31'd0, mem_write_en}, {31'd0, exp_we});
    if (g >= 0) begin
      run_m  = (g == own_m) ? ((run_m < MB) ? run_m + 1 : MB) : 1;
      own_m  = g;
      last_m = g;
      if (we[g]) ref_mem[exp_addr[7:0]] = exp_wd;
      else sb.push_back('{port: g, data: ref_mem[exp_addr[7:0]], due: cyc + 1});
    end else begin
      own_m = -1;
    end
  endtask

  task automatic idle();
    do_cycle(1'b0, 2'b00, 2'b00, 32'd0, 32'd0, 8'd0, 8'd0);
  endtask

  // Monitor: read-return strobes are compared against the scoreboard head.
  always @(negedge clk) begin
    logic [1:0] exp_rv;
    exp_rv = 2'b00;
    if (sb.size() > 0 && sb[0].due == cyc) exp_rv = (sb[0].port == 1) ? 2'b10 : 2'b01;
    chk("rvalid", {30'd0, bus.rvalid_o}, {30'd0, exp_rv});
    if (exp_rv != 2'b00) begin
      chk("rdata", {24'd0, bus.rdata_o}, {24'd0, sb[0].data});
      void'(sb.pop_front());
    end else if (sb.size() > 0 && sb[0].due < cyc) begin
      void'(sb.pop_front());
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    mem[8'h10]     = 8'hA5;
    ref_mem[8'h10] = 8'hA5;
    bus.req_i    = 2'b00;
    bus.we_i     = 2'b00;
    bus.addr0_i  = 32'd0;
    bus.addr1_i  = 32'd0;
    bus.wdata0_i = 8'd0;
    bus.wdata1_i = 8'd0;

    // Reset held with both ports requesting, then release.
    do_cycle(1'b1, 2'b11, 2'b11, 32'h4, 32'h8, 8'h11, 8'h22);
    do_cycle(1'b1, 2'b11, 2'b11, 32'h4, 32'h8, 8'h11, 8'h22);
    do_cycle(1'b0, 2'b11, 2'b00, 32'h4, 32'h8, 8'h11, 8'h22);
    chk("first_gnt_after_reset", {30'd0, bus.gnt_o}, 32'd1);
    idle();

    // Port 0 alone reads 0x10.
    do_cycle(1'b0, 2'b01, 2'b00, 32'h10, 32'h0, 8'h0, 8'h0);
    idle();

    // Port 1 writes 0x3C to 0x20, port 0 reads it back.
    do_cycle(1'b0, 2'b10, 2'b10, 32'h0, 32'h20, 8'h0, 8'h3C);
    do_cycle(1'b0, 2'b01, 2'b00, 32'h20, 32'h0, 8'h0, 8'h0);
    idle();

    // Port 0 was served last: simultaneous requests from idle go to port 1,
    // then continuous contention alternates in bursts of MB.
    do_cycle(1'b0, 2'b11, 2'b00, 32'h30, 32'h31, 8'h0, 8'h0);
    chk("idle_contention_port1", {30'd0, bus.gnt_o}, 32'd2);
    for (int i = 0; i < 12; i++)
      do_cycle(1'b0, 2'b11, 2'b00, 32'(8'h40 + i), 32'(8'h80 + i), 8'h0, 8'h0);
    idle();

    // Reset right after a port 1 read grant: the return is discarded.
    do_cycle(1'b0, 2'b10, 2'b00, 32'h0, 32'h20, 8'h0, 8'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    do_cycle(1'b1, 2'b11, 2'b00, 32'h50, 32'h60, 8'h0, 8'h0);
    do_cycle(1'b0, 2'b11, 2'b00, 32'h50, 32'h60, 8'h0, 8'h0);
    chk("gnt_after_mid_reset", {30'd0, bus.gnt_o}, 32'd1);

    // Randomized traffic, requests biased high to create contention.
    for (int i = 0; i < 400; i++) begin
      logic [1:0] r;
      r[0] = ($urandom_range(0, 3) != 0);
      r[1] = ($urandom_range(0, 3) != 0);
      do_cycle(1'b0, r, 2'($urandom_range(0, 3)), $urandom(), $urandom(),
               8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    idle();
    idle();
    idle();
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
